xor_sweep_checker: RTL and testbench



---
 rtl/xor_sweep_checker.sv | 112 +++++++++++
 tb/tb_xor_sweep_checker.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/xor_sweep_checker.sv
// Exhaustive sweep engine for N-input XOR/XNOR cells: walks every input vector,
// holds each for HOLD clocks, checks the DUT output against parity and logs errors.
module xor_sweep_checker #(
   parameter int N    = 2,
   parameter int HOLD = 5,
   parameter int HW   = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         inv,
   input  logic         dut_y,
   output logic [N-1:0] stim,
   output logic         busy,
   output logic         done,
   output logic         err_flag,
   output logic [N:0]   err_cnt,
   output logic [N-1:0] first_err_vec
);

   // state | meaning
   // IDLE  | waiting for start; stim parked at 0, done holds last result
   // RUN   | driving vec on stim, counting hold cycles, sampling dut_y
   // FIN   | single cycle after the last sample; done rises, back to IDLE
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
   localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
   localparam logic [N-1:0]  VEC_LAST  = '1;
   localparam logic [N-1:0]  VEC_ONE   = N'(1);
   localparam logic [N:0]    ERR_ONE   = (N + 1)'(1);

   state_t          state, state_nxt;
   logic [N-1:0]    vec, vec_nxt;
   logic [HW-1:0]   hold_cnt, hold_nxt;
   logic            inv_q, inv_nxt;
   logic            done_nxt;
   logic [N:0]      err_cnt_nxt;
   logic [N-1:0]    first_nxt;
   logic            exp_y;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         vec           <= '0;
         hold_cnt      <= '0;
         inv_q         <= 1'b0;
         done          <= 1'b0;
         err_cnt       <= '0;
         err_flag      <= 1'b0;
         first_err_vec <= '0;
      end else begin
         state         <= state_nxt;
         vec           <= vec_nxt;
         hold_cnt      <= hold_nxt;
         inv_q         <= inv_nxt;
         done          <= done_nxt;
         err_cnt       <= err_cnt_nxt;
         err_flag      <= |err_cnt_nxt;
         first_err_vec <= first_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      vec_nxt     = vec;
      hold_nxt    = hold_cnt;
      inv_nxt     = inv_q;
      done_nxt    = done;
      err_cnt_nxt = err_cnt;
      first_nxt   = first_err_vec;
      stim        = '0;
      busy        = 1'b0;
      exp_y       = (^vec) ^ inv_q;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt   = S_RUN;
               vec_nxt     = '0;
               hold_nxt    = '0;
               inv_nxt     = inv;
               done_nxt    = 1'b0;
               err_cnt_nxt = '0;
               first_nxt   = '0;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            stim = vec;
            // hold_cnt never passes HOLD_LAST, so equality marks the sample cycle
            if (hold_cnt != HOLD_LAST) begin
               hold_nxt = hold_cnt + HOLD_ONE;
            end else begin
               if (dut_y != exp_y) begin
                  err_cnt_nxt = err_cnt + ERR_ONE;
                  if (err_cnt == '0) first_nxt = vec;
               end
               if (vec == VEC_LAST) begin
                  state_nxt = S_FIN;
                  done_nxt  = 1'b1;
               end else begin
                  vec_nxt  = vec + VEC_ONE;
                  hold_nxt = '0;
               end
            end
         end
         S_FIN: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_xor_sweep_checker.sv
// Directed bench for xor_sweep_checker: a 2-input/HOLD=5 instance and a
// 4-input/HOLD=1 instance driven by modelled ideal and stuck-at DUTs.
module tb_xor_sweep_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, start_a, inv_a, start_b, inv_b;
   logic dut_y_a, dut_y_b;
   logic [1:0] stim_a, first_a;
   logic [2:0] err_cnt_a;
   logic busy_a, done_a, err_flag_a;
   logic [3:0] stim_b, first_b;
   logic [4:0] err_cnt_b;
   logic busy_b, done_b, err_flag_b;
   int mode_a, mode_b;   // 0 ideal XOR, 1 stuck-at-0, 2 stuck-at-1
   int n_pass = 0, n_total = 0;
   int cycles, seq_err;

   assign dut_y_a = (mode_a == 0) ? ^stim_a : (mode_a == 2);
   assign dut_y_b = (mode_b == 0) ? ^stim_b : (mode_b == 2);

   xor_sweep_checker #(.N(2), .HOLD(5), .HW(8)) u_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .inv(inv_a), .dut_y(dut_y_a),
      .stim(stim_a), .busy(busy_a), .done(done_a), .err_flag(err_flag_a),
      .err_cnt(err_cnt_a), .first_err_vec(first_a));

   xor_sweep_checker #(.N(4), .HOLD(1), .HW(8)) u_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .inv(inv_b), .dut_y(dut_y_b),
      .stim(stim_b), .busy(busy_b), .done(done_b), .err_flag(err_flag_b),
      .err_cnt(err_cnt_b), .first_err_vec(first_b));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   // Start a sweep on instance a; optionally pulse start, toggle inv or reset at a busy cycle.
   task automatic run_a(input int pulse_at, input int inv_at, input int rst_at,
                        output int n_cyc, output int n_seq);
      @(negedge clk) start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
      chk("a_busy_after_start", busy_a, 1);
      chk("a_done_cleared", done_a, 0);
      n_cyc = 0;
      n_seq = 0;
      while (busy_a && n_cyc < 200) begin
         if (stim_a !== 2'(n_cyc / 5)) n_seq++;
         start_a = (n_cyc == pulse_at);
         if (n_cyc == inv_at) inv_a = ~inv_a;
         if (n_cyc == rst_at) rst_n = 1'b0;
         n_cyc++;
         @(negedge clk);
      end
      rst_n   = 1'b1;
      start_a = 1'b0;
   endtask

   task automatic run_b(output int n_cyc, output int n_seq);
      @(negedge clk) start_b = 1'b1;
      @(negedge clk) start_b = 1'b0;
      chk("b_done_cleared", done_b, 0);
      n_cyc = 0;
      n_seq = 0;
      while (busy_b && n_cyc < 200) begin
         if (stim_b !== 4'(n_cyc)) n_seq++;
         n_cyc++;
         @(negedge clk);
      end
   endtask

   initial begin
      rst_n = 1'b0; start_a = 1'b0; inv_a = 1'b0; start_b = 1'b0; inv_b = 1'b0;
      mode_a = 0; mode_b = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("rst_stim", stim_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_err_cnt", err_cnt_a, 0);
      chk("rst_err_flag", err_flag_a, 0);
      chk("rst_first", first_a, 0);

      // ideal XOR
      run_a(-1, -1, -1, cycles, seq_err);
      chk("t1_cycles", cycles, 20);
      chk("t1_stim_seq", seq_err, 0);
      chk("t1_done", done_a, 1);
      chk("t1_err_cnt", err_cnt_a, 0);
      chk("t1_err_flag", err_flag_a, 0);
      chk("t1_first", first_a, 0);

      // stuck-at-0: vectors 01 and 10 fail
      mode_a = 1;
      run_a(-1, -1, -1, cycles, seq_err);
      chk("t2_cycles", cycles, 20);
      chk("t2_err_cnt", err_cnt_a, 2);
      chk("t2_first", first_a, 1);
      chk("t2_err_flag", err_flag_a, 1);
      chk("t2_done", done_a, 1);

      // expecting XNOR from an XOR cell: every vector fails; inv toggled mid-sweep
      mode_a = 0;
      inv_a  = 1'b1;
      run_a(-1, 5, -1, cycles, seq_err);
      inv_a  = 1'b0;
      chk("t3_cycles", cycles, 20);
      chk("t3_err_cnt", err_cnt_a, 4);
      chk("t3_first", first_a, 0);
      chk("t3_err_flag", err_flag_a, 1);

      // start pulse while busy is ignored
      run_a(3, -1, -1, cycles, seq_err);
      chk("t4_cycles", cycles, 20);
      chk("t4_stim_seq", seq_err, 0);
      chk("t4_err_cnt", err_cnt_a, 0);
      chk("t4_done", done_a, 1);

      // reset mid-sweep aborts with no partial done
      mode_a = 1;
      run_a(-1, -1, 7, cycles, seq_err);
      chk("t5_abort_cycles", cycles, 8);
      chk("t5_busy", busy_a, 0);
      chk("t5_done", done_a, 0);
      chk("t5_stim", stim_a, 0);
      chk("t5_err_cnt", err_cnt_a, 0);
      mode_a = 0;
      run_a(-1, -1, -1, cycles, seq_err);
      chk("t5_rerun_cycles", cycles, 20);
      chk("t5_rerun_done", done_a, 1);

      // N=4, HOLD=1
      run_b(cycles, seq_err);
      chk("t6_cycles", cycles, 16);
      chk("t6_stim_seq", seq_err, 0);
      chk("t6_err_cnt", err_cnt_b, 0);
      chk("t6_done", done_b, 1);
      @(negedge clk);
      chk("t6_done_sticky", done_b, 1);
      chk("t6_idle_busy", busy_b, 0);
      mode_b = 2;
      run_b(cycles, seq_err);
      chk("t6s_cycles", cycles, 16);
      chk("t6s_err_cnt", err_cnt_b, 8);
      chk("t6s_first", first_b, 0);
      chk("t6s_err_flag", err_flag_b, 1);
      chk("t6s_done", done_b, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
